// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default rates and the parity helper.
// Parity is compiled in only when UART_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int DEFAULT_BAUDRATE  = 9600;
    localparam int DEFAULT_CLOCKRATE = 100000000;

    // One-hot-style encodings shared with the receive side.
    localparam logic [3:0] STATUS_IDLE  = 4'd0;
    localparam logic [3:0] STATUS_BEGIN = 4'd1;
    localparam logic [3:0] STATUS_DATA  = 4'd2;
    localparam logic [3:0] STATUS_VALID = 4'd4;
    localparam logic [3:0] STATUS_END   = 4'd8;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO for uart_tx: DEPTH entries (power of two), pointers carry one extra
// bit so that full and empty can be told apart when the indices coincide.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem[rptr_q[AW-1:0]];

    // full is evaluated on the pre-pop pointers, so a push while full is dropped
    // even when a pop happens in the same cycle.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered 8N1 framing (8E1 when UART_PARITY_EN is defined),
// every bit held CLOCKRATE/BAUDRATE cycles, Tx registered and idle high.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUDRATE  = DEFAULT_BAUDRATE,
    parameter int CLOCKRATE = DEFAULT_CLOCKRATE,
    parameter int QUE_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_flag,
    input  logic [7:0] send_data,
    output logic       sendable,
    output logic       busy,
    output logic       Tx
);

    localparam int SAMPLE_INTERVAL = CLOCKRATE / BAUDRATE;
    localparam int CNT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_INTERVAL - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;
    logic       bit_done;

    tx_fifo #(
        .WIDTH(8),
        .DEPTH(QUE_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (send_flag),
        .pop  (fifo_pop),
        .din  (send_data),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign sendable = !fifo_full;
    assign busy     = (state_q != STATUS_IDLE) || !fifo_empty;
    assign Tx       = tx_q;
    assign bit_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_done ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            STATUS_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    idx_d    = 3'd0;
                    state_d  = STATUS_BEGIN;
`ifdef UART_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                end
            end
            STATUS_BEGIN: if (bit_done) state_d = STATUS_DATA;
            STATUS_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = STATUS_VALID;
`else
                        state_d = STATUS_END;
`endif
                    end
                end
            end
            STATUS_VALID: if (bit_done) state_d = STATUS_END;
            STATUS_END:   if (bit_done) state_d = STATUS_IDLE;
            default:      state_d = STATUS_IDLE;
        endcase
    end

    // Tx follows the current state, so the line lags the state register by one cycle.
    always_comb begin
        case (state_q)
            STATUS_BEGIN: tx_d = 1'b0;
            STATUS_DATA:  tx_d = shift_q[0];
`ifdef UART_PARITY_EN
            STATUS_VALID: tx_d = parity_q;
`endif
            default:      tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATUS_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_PARITY_EN
        parity_q <= parity_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit; frame length follows UART_PARITY_EN.
module tb_uart_tx;

    localparam int SI = 16;
`ifdef UART_PARITY_EN
    localparam int  NB  = 11;
    localparam bit  PAR = 1'b1;
`else
    localparam int  NB  = 10;
    localparam bit  PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       send_flag;
    logic [7:0] send_data;
    logic       sendable;
    logic       busy;
    logic       Tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] fill_b [17];
    logic [7:0] rnd;

    uart_tx #(
        .BAUDRATE (1),
        .CLOCKRATE(16),
        .QUE_DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .send_flag(send_flag),
        .send_data(send_data),
        .sendable (sendable),
        .busy     (busy),
        .Tx       (Tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit i of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (PAR && i == 9) return ^b;
        return 1'b1;
    endfunction

    // Called at a negedge: drives one push that lands on the next posedge.
    task automatic push1(input logic [7:0] b);
        send_flag = 1'b1;
        send_data = b;
        @(negedge clk);
        send_flag = 1'b0;
    endtask

    task automatic lead(input string tag);
        @(negedge clk);
        chk(tag, Tx, 1'b1);
    endtask

    task automatic check_frame(input logic [7:0] b, input bit idle_after, input string tag);
        for (int i = 0; i < NB; i++) begin
            int bad = 0;
            for (int c = 0; c < SI; c++) begin
                @(negedge clk);
                if (Tx !== exp_bit(b, i)) bad++;
                if (i == NB-1 && c == SI-2 && idle_after)
                    chk($sformatf("%s busy_before_end", tag), busy, 1'b1);
                if (i == NB-1 && c == SI-1 && idle_after)
                    chk($sformatf("%s busy_drop", tag), busy, 1'b0);
            end
            chk($sformatf("%s byte %02h bit%0d level %0d wrong_cycles", tag, b, i, exp_bit(b, i)),
                bad, 0);
        end
    endtask

    task automatic check_idle(input int n, input string tag);
        int bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (Tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk($sformatf("%s idle_violations", tag), bad, 0);
    endtask

    initial begin
        rst       = 1'b1;
        send_flag = 1'b0;
        send_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset Tx", Tx, 1'b1);
        chk("reset sendable", sendable, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset Tx", Tx, 1'b1);
        chk("post_reset busy", busy, 1'b0);

        // Single frames from idle: exact start latency and busy release.
        push1(8'hA5);
        chk("a5 busy_after_push", busy, 1'b1);
        lead("a5 lead");
        check_frame(8'hA5, 1'b1, "a5");
        push1(8'h01);
        lead("01 lead");
        check_frame(8'h01, 1'b1, "01");
        for (int k = 0; k < 4; k++) begin
            rnd = 8'($urandom);
            push1(rnd);
            lead($sformatf("rnd%0d lead", k));
            check_frame(rnd, 1'b1, $sformatf("rnd%0d", k));
        end
        check_idle(5, "after_singles");

        // Back-to-back pushes: frames separated by exactly one high cycle.
        send_flag = 1'b1;
        send_data = 8'h55;
        @(negedge clk);
        send_data = 8'hFF;
        @(negedge clk);
        send_flag = 1'b0;
        chk("b2b lead", Tx, 1'b1);
        check_frame(8'h55, 1'b0, "b2b_first");
        lead("b2b gap");
        check_frame(8'hFF, 1'b1, "b2b_second");

        // Fill the FIFO during an active frame; the 17th push must be dropped.
        rnd = 8'($urandom);
        for (int i = 0; i < 17; i++) fill_b[i] = 8'($urandom);
        send_flag = 1'b1;
        send_data = rnd;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    chk($sformatf("fill sendable_before_push%0d", i), sendable, (i < 16) ? 1'b1 : 1'b0);
                    send_flag = 1'b1;
                    send_data = fill_b[i];
                    @(negedge clk);
                end
                send_flag = 1'b0;
                chk("fill sendable_full", sendable, 1'b0);
                chk("fill busy", busy, 1'b1);
            end
            begin
                lead("fill lead");
                check_frame(rnd, 1'b0, "fill_head");
                for (int j = 0; j < 16; j++) begin
                    lead($sformatf("fill gap%0d", j));
                    check_frame(fill_b[j], (j == 15), $sformatf("fill%0d", j));
                end
            end
        join
        chk("fill drained sendable", sendable, 1'b1);
        check_idle(20, "after_fill");

        // Reset 40 cycles into a frame with a second byte queued.
        send_flag = 1'b1;
        send_data = 8'($urandom);
        @(negedge clk);
        send_data = 8'($urandom);
        @(negedge clk);
        send_flag = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset Tx", Tx, 1'b1);
        chk("midreset busy", busy, 1'b0);
        chk("midreset sendable", sendable, 1'b1);
        check_idle(20, "after_midreset");
        push1(8'h3C);
        lead("3c lead");
        check_frame(8'h3C, 1'b1, "3c");
        check_idle(2 * SI * NB, "after_3c");

        // Push coincident with reset must not be stored.
        rst       = 1'b1;
        send_flag = 1'b1;
        send_data = 8'($urandom);
        @(negedge clk);
        rst       = 1'b0;
        send_flag = 1'b0;
        chk("rst_push busy", busy, 1'b0);
        chk("rst_push sendable", sendable, 1'b1);
        check_idle(40, "after_rst_push");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
